// File: rtl/mem_resp_mc_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_mc_pkg
// Shared definitions for the multi-cycle data-memory responder:
//   - access size encodings (byte / half / word / reserved)
//   - responder FSM state encoding
//   - log2 helper used to size the word index and latency counter
// No ports (package).
// -----------------------------------------------------------------------------
package mem_resp_mc_pkg;

  // Access size encodings carried on req_size (funct3[1:0] of the load/store).
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Responder FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StResp = 2'b10
  } resp_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_resp_mc_if.sv
// -----------------------------------------------------------------------------
// mem_resp_mc_if
// Request/response bus between the core's control FSM (master) and the data
// memory responder (slave).
//   req_valid    : request present (held by master until accepted)
//   req_ready    : responder idle; accept on req_valid && req_ready
//   req_wr       : 1 = store, 0 = load
//   req_size     : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned : zero-extend loads
//   req_addr     : byte address
//   req_wdata    : right-aligned store data
//   rsp_valid    : one-cycle completion pulse
//   rsp_rdata    : extended load data (0 for stores)
//   rsp_err      : misalignment error, valid with rsp_valid
// -----------------------------------------------------------------------------
interface mem_resp_mc_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_wr,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_wr,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for the data memory responder.
//   i_size     : access size (SIZE_* encodings; reserved treated as word)
//   i_unsigned : zero-extend loads instead of sign-extending
//   i_addr_lo  : already-aligned low address bits selecting the lane(s)
//   i_wdata    : right-aligned store data
//   i_rword    : 32-bit word read from storage
//   o_be       : store byte enables
//   o_wdata    : store data replicated across all lanes
//   o_rdata    : extracted and extended load data
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_resp_mc_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane extraction for loads.
  always_comb begin
    w_byte = i_rword[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rword;
    case (i_size)
      SIZE_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      end
      SIZE_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
      end
      // Word and reserved: all lanes, no extension.
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
      end
    endcase
  end

endmodule

// File: rtl/mem_resp_mc.sv
// -----------------------------------------------------------------------------
// mem_resp_mc
// Multi-cycle data-memory responder. Accepts one load/store at a time, waits a
// fixed LATENCY, performs the access with byte/half/word lane steering and
// returns a one-cycle response pulse.
//
// Parameters:
//   DEPTH_WORDS : storage depth in 32-bit words (power of two, >= 2)
//   LATENCY     : clock edges from acceptance to rsp_valid (>= 1)
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : mem_resp_mc_if.slave request/response bus
// Configuration macro:
//   MEM_MISALIGN_TRAP_EN : when defined, misaligned (and reserved-size)
//     requests complete with rsp_err=1, rsp_rdata=0 and no memory update.
//     When undefined, low address bits are forced to alignment and rsp_err=0.
// -----------------------------------------------------------------------------
module mem_resp_mc
  import mem_resp_mc_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic          clk,
  input logic          rst,
  mem_resp_mc_if.slave bus
);

  localparam int unsigned IdxW  = log2_ceil(DEPTH_WORDS);
  localparam int unsigned AddrW = IdxW + 2;
  localparam int unsigned CntW  = (LATENCY > 1) ? log2_ceil(LATENCY) : 1;

  // FSM and counter
  resp_state_e r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            w_accept;
  logic            w_access;

  // Latched request
  logic             r_wr;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [AddrW-1:0] r_addr;
  logic [31:0]      r_wdata;

  // Registered response
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  // Storage (not reset)
  logic [31:0] r_mem [DEPTH_WORDS];

  // Access datapath
  logic [IdxW-1:0] w_idx;
  logic [1:0]      w_addr_lo;
  logic [31:0]     w_rword;
  logic [3:0]      w_be;
  logic [31:0]     w_st_data;
  logic [31:0]     w_ld_data;
  logic            w_err;
  logic            w_we;

  // Address bits above the storage range are ignored so accesses wrap.
  logic w_unused_addr;
  assign w_unused_addr = ^bus.req_addr[31:AddrW];

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          w_accept  = 1'b1;
          w_cnt_d   = CntW'(LATENCY - 1);
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt == '0) begin
          w_access  = 1'b1;
          w_state_d = StResp;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StResp: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_accept) begin
      r_wr       <= bus.req_wr;
      r_size     <= bus.req_size;
      r_unsigned <= bus.req_unsigned;
      r_addr     <= bus.req_addr[AddrW-1:0];
      r_wdata    <= bus.req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Access datapath
  // ---------------------------------------------------------------------------
  assign w_idx = r_addr[AddrW-1:2];

  // Force alignment of the lane select; with trapping enabled a misaligned
  // request never commits, so the forced value only matters for the
  // non-trapping build.
  always_comb begin
    w_addr_lo = 2'b00;
    case (r_size)
      SIZE_BYTE: w_addr_lo = r_addr[1:0];
      SIZE_HALF: w_addr_lo = {r_addr[1], 1'b0};
      default:   w_addr_lo = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic w_misalign;
  always_comb begin
    w_misalign = 1'b0;
    case (r_size)
      SIZE_BYTE: w_misalign = 1'b0;
      SIZE_HALF: w_misalign = r_addr[0];
      default:   w_misalign = (r_addr[1:0] != 2'b00);
    endcase
  end
  assign w_err = w_misalign | (r_size == SIZE_RSVD);
`else
  assign w_err = 1'b0;
`endif

  assign w_rword = r_mem[w_idx];

  mem_lane_align u_lane_align (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_addr_lo  (w_addr_lo),
    .i_wdata    (r_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .o_rdata    (w_ld_data)
  );

  // A reset on the commit edge abandons the store.
  assign w_we = w_access & r_wr & ~w_err & ~rst;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_access) begin
      r_rsp_rdata <= (r_wr | w_err) ? 32'd0 : w_ld_data;
      r_rsp_err   <= w_err;
    end
  end

  assign bus.req_ready = (r_state == StIdle);
  assign bus.rsp_valid = (r_state == StResp);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_resp_mc.sv
// -----------------------------------------------------------------------------
// tb_mem_resp_mc
// Directed, table-driven bench for mem_resp_mc (DEPTH_WORDS=16, LATENCY=3),
// plus hand-written sequences for ignored requests during BUSY and reset
// abandoning an in-flight store. Expected values follow MEM_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_mem_resp_mc;
  import mem_resp_mc_pkg::*;

  localparam int unsigned Depth = 16;
  localparam int unsigned Lat   = 3;

  logic clk;
  logic rst;
  mem_resp_mc_if bus ();

  mem_resp_mc #(
    .DEPTH_WORDS (Depth),
    .LATENCY     (Lat)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NumVec = 24;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, wait for its response, and report latency in edges
  // after the acceptance edge (0 on timeout).
  task automatic run_req(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    int waitn;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_wr       = wr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    waitn = 0;
    while (!bus.req_ready && waitn < 20) begin
      @(negedge clk);
      waitn++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    for (int k = 1; k <= 4 * Lat + 4; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat   = k;
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
    check("ready_after_resp", 32'(bus.req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;
  int          seen;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0_after_mis;
    logic [31:0] mis_rdata;
    logic        mis_err;
    logic [31:0] rsvd_rdata;

    checks   = 0;
    failures = 0;

`ifdef MEM_MISALIGN_TRAP_EN
    w0_after_mis = 32'h8001F00D;
    mis_rdata    = 32'h0;
    mis_err      = 1'b1;
    rsvd_rdata   = 32'h0;
`else
    w0_after_mis = 32'h1234F00D;
    mis_rdata    = 32'h1234F00D;
    mis_err      = 1'b0;
    rsvd_rdata   = 32'hDEADBEEF;
`endif

    //           wr    size       uns   addr          wdata         exp_rdata     exp_err
    vecs[0]  = '{1'b1, SIZE_WORD, 1'b0, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, SIZE_WORD, 1'b1, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, SIZE_WORD, 1'b0, 32'h00000004, 32'h11223344, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b1, SIZE_BYTE, 1'b0, 32'h00000005, 32'h12345680, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b0, SIZE_BYTE, 1'b0, 32'h00000005, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, SIZE_BYTE, 1'b1, 32'h00000005, 32'h0,        32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, SIZE_WORD, 1'b0, 32'h00000004, 32'h0,        32'h11228044, 1'b0};
    vecs[7]  = '{1'b1, SIZE_WORD, 1'b0, 32'h00000000, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, SIZE_HALF, 1'b0, 32'h00000002, 32'hABCD8001, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, SIZE_HALF, 1'b0, 32'h00000002, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[10] = '{1'b0, SIZE_HALF, 1'b1, 32'h00000002, 32'h0,        32'h00008001, 1'b0};
    vecs[11] = '{1'b0, SIZE_WORD, 1'b0, 32'h00000000, 32'h0,        32'h8001F00D, 1'b0};
    vecs[12] = '{1'b0, SIZE_BYTE, 1'b0, 32'h00000001, 32'h0,        32'hFFFFFFF0, 1'b0};
    vecs[13] = '{1'b0, SIZE_HALF, 1'b1, 32'h00000000, 32'h0,        32'h0000F00D, 1'b0};
    vecs[14] = '{1'b0, SIZE_HALF, 1'b0, 32'h00000000, 32'h0,        32'hFFFFF00D, 1'b0};
    vecs[15] = '{1'b1, SIZE_HALF, 1'b0, 32'h00000003, 32'h00001234, 32'h00000000, mis_err};
    vecs[16] = '{1'b0, SIZE_WORD, 1'b0, 32'h00000000, 32'h0,        w0_after_mis, 1'b0};
    vecs[17] = '{1'b0, SIZE_WORD, 1'b0, 32'h00000002, 32'h0,        mis_rdata,    mis_err};
    vecs[18] = '{1'b0, SIZE_RSVD, 1'b0, 32'h00000010, 32'h0,        rsvd_rdata,   mis_err};
    vecs[19] = '{1'b1, SIZE_WORD, 1'b0, 32'h00000024, 32'h11111111, 32'h00000000, 1'b0};
    vecs[20] = '{1'b0, SIZE_BYTE, 1'b1, 32'h00000007, 32'h0,        32'h00000011, 1'b0};
    vecs[21] = '{1'b1, SIZE_WORD, 1'b0, 32'h00000040, 32'h5A5A0001, 32'h00000000, 1'b0};
    vecs[22] = '{1'b0, SIZE_WORD, 1'b0, 32'h00000000, 32'h0,        32'h5A5A0001, 1'b0};
    vecs[23] = '{1'b0, SIZE_WORD, 1'b0, 32'h00000050, 32'h0,        32'hDEADBEEF, 1'b0};

    bus.req_valid    = 1'b0;
    bus.req_wr       = 1'b0;
    bus.req_size     = SIZE_BYTE;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    rst              = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      run_req(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lt);
      check($sformatf("vec%0d_latency", i), 32'(lt), 32'(Lat));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // req_valid pulses during BUSY must not be accepted.
    @(negedge clk);
    check("busy_pre_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_size  = SIZE_WORD;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h24;
    bus.req_wdata = 32'hFFFFFFFF;
    for (int k = 0; k < int'(Lat) - 1; k++) begin
      @(negedge clk);
      check($sformatf("busy_ready_low%0d", k), 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 4 * int'(Lat) && seen == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1;
    end
    check("busy_store_resp", 32'(seen), 32'd1);
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h24, 32'h0, rd, er, lt);
    check("busy_ignored_data", rd, 32'h11111111);
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, rd, er, lt);
    check("busy_store_data", rd, 32'hA5A5A5A5);

    // Reset one cycle into BUSY of a store abandons it.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_size  = SIZE_WORD;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h01020304;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 2 * int'(Lat) + 2; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1;
    end
    check("rst_no_rsp_pulse", 32'(seen), 32'd0);
    run_req(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, rd, er, lt);
    check("rst_old_data", rd, 32'hDEADBEEF);
    check("rst_load_latency", 32'(lt), 32'(Lat));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
